// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronizes and debounces encoder A/B, then emits registered
// one-cycle step pulses with direction for a downstream up/down counter.
module quad_step_decoder #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic enc_a,
   input  logic enc_b,
   input  logic run,
   input  logic err_clr,
   output logic step_en,
   output logic step_dir,
   output logic err
);

   // Gray-coded positions, bit 1 = A, bit 0 = B
   localparam logic [1:0] StS00 = 2'b00;
   localparam logic [1:0] StS01 = 2'b01;
   localparam logic [1:0] StS11 = 2'b11;
   localparam logic [1:0] StS10 = 2'b10;

   localparam logic [3:0] FiltLimit = 4'(FILT_CYCLES);

   logic [SYNC_STAGES-1:0] sync_a_q;
   logic [SYNC_STAGES-1:0] sync_b_q;
   logic [1:0]             synced;

   logic [1:0][3:0] cnt_q, cnt_d;
   logic [1:0]      filt_q, filt_d;
   logic [1:0]      state_q;
   logic [1:0]      fwd_next;
   logic [1:0]      change;
   logic            illegal;
   logic            single;

   logic step_en_q, step_en_d;
   logic step_dir_q, step_dir_d;
   logic err_q, err_d;

   always_ff @(posedge clock) begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], enc_a};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], enc_b};
   end

   assign synced = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

   // Per-bit debounce: count consecutive samples that disagree with the filtered value
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      for (int i = 0; i < 2; i++) begin
         if (synced[i] != filt_q[i]) begin
            if (cnt_q[i] + 4'd1 == FiltLimit) begin
               filt_d[i] = synced[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 4'd1;
            end
         end
      end
   end

   always_comb begin
      fwd_next = StS00;
      unique case (state_q)
         StS00:   fwd_next = StS01;
         StS01:   fwd_next = StS11;
         StS11:   fwd_next = StS10;
         StS10:   fwd_next = StS00;
         default: fwd_next = StS00;
      endcase
   end

   assign change  = filt_q ^ state_q;
   assign illegal = &change;
   assign single  = ^change;

   always_comb begin
      step_en_d  = single & run;
      step_dir_d = step_dir_q;
      if (step_en_d) begin
         step_dir_d = (filt_q == fwd_next);
      end
      // An illegal change on the clearing edge wins over the clear
      err_d = illegal | (err_q & ~err_clr);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q      <= '0;
         filt_q     <= synced;
         state_q    <= synced;
         step_en_q  <= 1'b0;
         step_dir_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         filt_q     <= filt_d;
         state_q    <= filt_q;
         step_en_q  <= step_en_d;
         step_dir_q <= step_dir_d;
         err_q      <= err_d;
      end
   end

   assign step_en  = step_en_q;
   assign step_dir = step_dir_q;
   assign err      = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: a window-based reference model predicts step pulses
// and err/step_dir levels from the raw encoder history; a negedge monitor checks the DUT.
module tb_quad_step_decoder;

   localparam int SYNC   = 2;
   localparam int FILT   = 4;
   localparam int MaxCyc = 16384;

   logic clock = 1'b0;
   logic reset, enc_a, enc_b, run, err_clr;
   logic step_en, step_dir, err;

   quad_step_decoder #(
      .SYNC_STAGES(SYNC),
      .FILT_CYCLES(FILT)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .enc_a   (enc_a),
      .enc_b   (enc_b),
      .run     (run),
      .err_clr (err_clr),
      .step_en (step_en),
      .step_dir(step_dir),
      .err     (err)
   );

   always #5 clock = ~clock;

   typedef struct {
      int cyc;
      bit dir;
   } step_t;

   step_t exp_q[$];
   int    vectors    = 0;
   int    miscompares = 0;
   int    cyc        = 0;
   int    step_seen  = 0;

   logic [1:0] raw_h [MaxCyc];
   bit         rst_h [MaxCyc];
   logic [1:0] mfilt = 2'b00;
   bit         pend = 0;
   logic [1:0] pend_old, pend_new;
   bit         err_exp = 0;
   bit         dir_exp = 0;

   function automatic int pos(input logic [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic check_bit(input string name, input logic act, input logic req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %b, expected %b", name, cyc, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, req);
      end
   endtask

   // Reference model: a filtered bit flips once the last FILT synchronized samples (each one
   // SYNC edges old, none taken on a reset edge) all oppose it; the output reacts one edge later.
   always @(posedge clock) begin
      logic [1:0] newf;
      bit ok;
      int e;
      cyc++;
      if (cyc >= MaxCyc) begin
         $display("FAIL cycle_budget: edge %0d exceeds history of %0d", cyc, MaxCyc);
         $fatal(1, "history exhausted");
      end
      raw_h[cyc] = {enc_a, enc_b};
      rst_h[cyc] = !reset;
      if (!reset) begin
         mfilt   = raw_h[(cyc > SYNC) ? cyc - SYNC : 1];
         pend    = 0;
         err_exp = 0;
         dir_exp = 0;
      end else begin
         if (pend && (pend_old ^ pend_new) == 2'b11) begin
            err_exp = 1;
         end else begin
            if (err_clr) err_exp = 0;
            if (pend && run) begin
               dir_exp = (((pos(pend_new) - pos(pend_old) + 4) % 4) == 1);
               exp_q.push_back('{cyc: cyc, dir: dir_exp});
            end
         end
         pend = 0;
         newf = mfilt;
         for (int b = 0; b < 2; b++) begin
            ok = 1;
            for (int j = 0; j < FILT; j++) begin
               e = cyc - j;
               if (e - SYNC < 1 || rst_h[e]) ok = 0;
               else if (raw_h[e-SYNC][b] == mfilt[b]) ok = 0;
            end
            if (ok) newf[b] = ~mfilt[b];
         end
         if (newf != mfilt) begin
            pend     = 1;
            pend_old = mfilt;
            pend_new = newf;
         end
         mfilt = newf;
      end
   end

   // Monitor
   always @(negedge clock) begin
      step_t s;
      if (cyc >= 1) begin
         check_bit("err", err, err_exp);
         check_bit("step_dir", step_dir, dir_exp);
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            s = exp_q.pop_front();
            check_int("step_missing_edge", cyc, s.cyc);
         end
         if (step_en === 1'b1) begin
            step_seen++;
            if (exp_q.size() == 0) begin
               check_int("step_unexpected", 1, 0);
            end else begin
               s = exp_q.pop_front();
               check_int("step_edge", cyc, s.cyc);
               check_bit("step_dir_on_step", step_dir, s.dir);
            end
         end
      end
   end

   task automatic hold(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic drive(input logic [1:0] v);
      enc_a = v[1];
      enc_b = v[0];
   endtask

   initial begin
      int s0;
      logic [1:0] cur;
      int r, p;
      reset   = 1'b0;
      run     = 1'b1;
      err_clr = 1'b0;
      drive(2'b11);

      // Reset release with encoder at 11
      hold(5);
      reset = 1'b1;
      s0 = step_seen;
      hold(20);
      check_int("release_steps", step_seen - s0, 0);
      check_bit("release_err", err, 1'b0);
      check_bit("release_dir", step_dir, 1'b0);

      drive(2'b10); hold(10);
      drive(2'b00); hold(10);

      // Forward sequence
      s0 = step_seen;
      drive(2'b01); hold(10);
      drive(2'b11); hold(10);
      drive(2'b10); hold(10);
      drive(2'b00); hold(10);
      check_int("fwd_steps", step_seen - s0, 4);
      check_bit("fwd_dir", step_dir, 1'b1);

      // Reverse step then a short glitch on B
      s0 = step_seen;
      drive(2'b10); hold(10);
      enc_b = 1'b1; hold(3);
      enc_b = 1'b0; hold(12);
      check_int("rev_glitch_steps", step_seen - s0, 1);
      check_bit("rev_dir", step_dir, 1'b0);
      check_bit("glitch_err", err, 1'b0);
      drive(2'b00); hold(10);

      // Illegal change, later clear, then clear coincident with another illegal change
      s0 = step_seen;
      drive(2'b11); hold(10);
      check_bit("illegal_err", err, 1'b1);
      check_int("illegal_steps", step_seen - s0, 0);
      err_clr = 1'b1; hold(1);
      err_clr = 1'b0; hold(2);
      check_bit("cleared_err", err, 1'b0);
      drive(2'b00); hold(6);
      err_clr = 1'b1; hold(1);
      err_clr = 1'b0; hold(5);
      check_bit("coincident_clear_err", err, 1'b1);
      check_int("illegal2_steps", step_seen - s0, 0);
      err_clr = 1'b1; hold(1);
      err_clr = 1'b0; hold(2);

      // Run gate, then reset during a pending filter count
      s0 = step_seen;
      run = 1'b0; drive(2'b01); hold(10);
      run = 1'b1; drive(2'b11); hold(10);
      check_int("run_gate_steps", step_seen - s0, 1);
      check_bit("run_gate_dir", step_dir, 1'b1);
      s0 = step_seen;
      drive(2'b10); hold(3);
      reset = 1'b0; hold(4);
      reset = 1'b1; hold(15);
      check_int("mid_reset_steps", step_seen - s0, 0);

      // Randomized traffic
      cur = 2'b10;
      for (int it = 0; it < 300; it++) begin
         r   = $urandom_range(0, 9);
         run = ($urandom_range(0, 3) != 0);
         err_clr = ($urandom_range(0, 7) == 0);
         if (r <= 6) begin
            p = (pos(cur) + (($urandom_range(0, 1) != 0) ? 1 : 3)) % 4;
            case (p)
               0:       cur = 2'b00;
               1:       cur = 2'b01;
               2:       cur = 2'b11;
               default: cur = 2'b10;
            endcase
            drive(cur);
         end else if (r == 7) begin
            drive(cur ^ (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01));
            hold($urandom_range(1, FILT - 1));
            drive(cur);
         end else if (r == 8) begin
            cur = ~cur;
            drive(cur);
         end else begin
            reset = 1'b0;
            hold($urandom_range(SYNC + 1, 6));
            reset = 1'b1;
         end
         hold($urandom_range(1, 12));
      end

      run = 1'b1;
      err_clr = 1'b0;
      hold(20);
      check_int("pending_steps_at_end", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/quad_step_decoder.md
QUAD_STEP_DECODER -- requirements
Module: quad_step_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth per encoder input (legal 2..4).
REQ-002 SHALL have parameter FILT_CYCLES, default 4, consecutive stable samples required before a filtered input changes (legal 1..15).
REQ-003 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port enc_a  input  1  quadrature channel A, asynchronous to clock.
REQ-006 SHALL have port enc_b  input  1  quadrature channel B, asynchronous to clock.
REQ-007 SHALL have port run  input  1  step output gate; 0 suppresses step_en, tracking continues.
REQ-008 SHALL have port err_clr  input  1  synchronous clear of sticky err.
REQ-009 SHALL have port step_en  output  1  one-cycle step pulse, drives the downstream up/down counter's enable.
REQ-010 SHALL have port step_dir  output  1  direction, 1 = up, 0 = down; drives the counter's up_down.
REQ-011 SHALL have port err  output  1  sticky illegal-transition flag.

Function
REQ-012 SHALL pass enc_a and enc_b each through an independent SYNC_STAGES-flop synchronizer; synchronizer flops carry no reset.
REQ-013 SHALL filter each synchronized bit independently: per-bit counter increments on every edge where synced value differs from filtered value, clears on any edge where they match.
REQ-014 SHALL update a filtered bit to its synced value on the edge where its counter reaches FILT_CYCLES, clearing that counter on the same edge.
REQ-015 SHALL hold a 2-bit state register {A,B} equal to the filtered pair as of the previous edge, forming a four-state Gray FSM: 00, 01, 11, 10.
REQ-016 SHALL treat 00->01->11->10->00 as forward (up) and the reverse order as down.
REQ-017 SHALL, on a single-bit forward change with run=1, assert step_en for exactly one cycle with step_dir=1 on the same cycle.
REQ-018 SHALL, on a single-bit reverse change with run=1, assert step_en for exactly one cycle with step_dir=0 on the same cycle.
REQ-019 SHALL keep step_dir at its last value when step_en is 0.
REQ-020 SHALL, on a single-bit change with run=0, produce no step_en, leave step_dir unchanged, and still advance the state register.
REQ-021 SHALL, when both filtered bits change on the same edge, set err=1, produce no step, and adopt the new pair as the state, regardless of run.
REQ-022 SHALL clear err on an edge with err_clr=1, except that an illegal change on that same edge leaves err=1.
REQ-023 SHALL register all outputs.
REQ-024 SHALL give latency from the first edge sampling a new stable level to step_en high of exactly SYNC_STAGES+FILT_CYCLES+1 edges (7 with defaults).
REQ-025 SHALL ignore any pulse on an input shorter than FILT_CYCLES synchronized samples, with no step and no err.
REQ-026 SHALL produce at most one step per edge, with no counter wrap concerns; direction reversal between steps is legal.

Reset
REQ-027 SHALL, while reset=0 at an edge, force step_en=0, step_dir=0, err=0, and both filter counters to 0.
REQ-028 SHALL, while reset=0 at an edge, load the filtered bits and state register directly from the synchronizer outputs, so encoder position at release creates no step or err.
REQ-029 SHALL, on reset asserted mid-filter or mid-pulse, discard the pending change and drop step_en on the next edge.
REQ-030 SHALL, in the bench, hold reset low at least SYNC_STAGES+1 cycles with defined encoder levels.

Verification
REQ-031 SHALL verify a reset release sequence: enc=11 during reset, release, hold 20 cycles -> step_en never 1, err=0, step_dir=0.
REQ-032 SHALL verify a forward sequence (defaults): from 00, drive 01, 11, 10, 00, each held 10 cycles -> four step_en pulses, each 7 edges after its change, step_dir=1.
REQ-033 SHALL verify a reverse then glitch sequence: from 00, drive 10, then a 3-cycle pulse on enc_b -> one step with step_dir=0, glitch yields no step and no err.
REQ-034 SHALL verify an illegal change with simultaneous clear: from 00, drive A and B to 11 on the same cycle -> err=1, no step; assert err_clr on a later idle edge -> err=0; repeat with err_clr coincident with the filtered 11->00 edge -> err stays 1.
REQ-035 SHALL verify the run gate and mid-operation reset: run=0 with forward 00->01, then run=1 with 01->11 -> exactly one step_en, step_dir=1; reset pulse during a pending filter count -> no step_en after release.
